// File: rtl/nes_io_pkg.sv
// Shared constants and types for the NES controller port logic.
package nes_io_pkg;

  localparam logic [15:0] CONTROLLER1_ADDR = 16'h4016;
  localparam logic [15:0] CONTROLLER2_ADDR = 16'h4017;

  typedef enum logic [2:0] {
    LATCH,
    HIGH,
    LOW,
    COMMIT,
    WAIT
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/joypad_scanner.sv
// Autonomous pad scanner: latches the pads, clocks their bits out LSB first and
// publishes a complete snapshot once per poll period.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  LATCH  | pad_latch high, pads parallel-load their buttons
//  HIGH   | pad_clk high; last cycle samples the current bit
//  LOW    | pad_clk low; the rising edge on exit advances the pads
//  COMMIT | working register becomes the published snapshot
//  WAIT   | idle until the poll period since LATCH entry has elapsed
module joypad_scanner
  import nes_io_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int HALF_CYC    = 4,
  parameter int LATCH_CYC   = 12,
  parameter int POLL_PERIOD = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PADS-1:0]          pad_data_n,
  output logic [NUM_PADS-1:0]          pad_clk,
  output logic                         pad_latch,
  output logic [NUM_PADS*NUM_BITS-1:0] snapshot,
  output logic [NUM_PADS*NUM_BITS-1:0] snapshot_next,
  output logic                         commit
);

  localparam int CW = $clog2(max_int(LATCH_CYC, HALF_CYC) + 1);
  localparam int BW = $clog2(NUM_BITS);
  localparam int PW = $clog2(POLL_PERIOD + 1);

  scan_state_e state, state_next;

  logic [CW-1:0] phase_cnt;
  logic [BW-1:0] bit_idx;
  logic [PW-1:0] poll_cnt;
  logic          phase_done;
  logic          last_bit;

  logic [NUM_PADS-1:0][NUM_BITS-1:0] work;

  assign phase_done    = (phase_cnt == '0);
  assign last_bit      = (bit_idx == BW'(NUM_BITS - 1));
  assign snapshot_next = work;

  // Reset parks in WAIT with an expired poll timer, so LATCH follows immediately.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LATCH:   if (phase_done) state_next = HIGH;
      HIGH:    if (phase_done) state_next = LOW;
      LOW:     if (phase_done) state_next = last_bit ? COMMIT : HIGH;
      COMMIT:  state_next = WAIT;
      WAIT:    if (poll_cnt == '0) state_next = LATCH;
      default: state_next = WAIT;
    endcase
  end

  always_comb begin
    pad_latch = 1'b0;
    pad_clk   = '1;
    commit    = 1'b0;
    unique case (state)
      LATCH:   pad_latch = 1'b1;
      LOW:     pad_clk   = '0;
      COMMIT:  commit    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
      bit_idx   <= '0;
      poll_cnt  <= '0;
    end else begin
      if (state_next != state) begin
        unique case (state_next)
          LATCH:     phase_cnt <= CW'(LATCH_CYC - 1);
          HIGH, LOW: phase_cnt <= CW'(HALF_CYC - 1);
          default:   phase_cnt <= '0;
        endcase
      end else if (!phase_done) begin
        phase_cnt <= phase_cnt - 1'b1;
      end

      if (state == LATCH)                 bit_idx <= '0;
      else if (state == LOW && phase_done) bit_idx <= bit_idx + 1'b1;

      // Poll period is measured from LATCH entry, independent of scan length.
      if (state_next == LATCH && state != LATCH) poll_cnt <= PW'(POLL_PERIOD - 1);
      else if (poll_cnt != '0)                  poll_cnt <= poll_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      snapshot <= '0;
    end else begin
      if (state == HIGH && phase_done) begin
        for (int p = 0; p < NUM_PADS; p++) work[p][bit_idx] <= ~pad_data_n[p];
      end
      if (state == COMMIT) snapshot <= work;
    end
  end

endmodule

// File: rtl/joypad_poller.sv
// NES controller port: CPU bus decode, strobe register and 4021-style CPU shift
// registers fed from the scanner's snapshot, so CPU reads never touch the pad wires.
module joypad_poller
  import nes_io_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int HALF_CYC    = 4,
  parameter int LATCH_CYC   = 12,
  parameter int POLL_PERIOD = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ph2_falling,
  input  logic [15:0]                  cpu_addr,
  input  logic                         cpu_rnw,
  input  logic                         cpu_data_in,
  output logic [7:0]                   cpu_data_out,
  input  logic [NUM_PADS-1:0]          pad_data_n,
  output logic [NUM_PADS-1:0]          pad_clk,
  output logic                         pad_latch,
  output logic [NUM_PADS*NUM_BITS-1:0] pad_state,
  output logic                         scan_done
);

  logic [NUM_PADS*NUM_BITS-1:0] snap_next;
  logic [NUM_PADS*NUM_BITS-1:0] load_src;
  logic                         commit;
  logic                         strobe;
  logic                         strobe_wr;
  logic                         sel1;
  logic                         sel2;
  logic                         pad1_d0;
  logic [NUM_PADS-1:0]          rd_sel;

  logic [NUM_PADS-1:0][NUM_BITS-1:0] sreg;

  joypad_scanner #(
    .NUM_PADS    (NUM_PADS),
    .NUM_BITS    (NUM_BITS),
    .HALF_CYC    (HALF_CYC),
    .LATCH_CYC   (LATCH_CYC),
    .POLL_PERIOD (POLL_PERIOD)
  ) u_scanner (
    .clk           (clk),
    .rst           (rst),
    .pad_data_n    (pad_data_n),
    .pad_clk       (pad_clk),
    .pad_latch     (pad_latch),
    .snapshot      (pad_state),
    .snapshot_next (snap_next),
    .commit        (commit)
  );

  assign scan_done = commit;
  assign sel1      = (cpu_addr == CONTROLLER1_ADDR);
  assign sel2      = (cpu_addr == CONTROLLER2_ADDR);
  assign strobe_wr = ph2_falling & ~cpu_rnw & sel1;
  assign rd_sel[0] = cpu_rnw & sel1;

  // A strobe release landing on the COMMIT cycle takes the fresh snapshot.
  assign load_src = commit ? snap_next : pad_state;

  generate
    if (NUM_PADS > 1) begin : g_pad1
      assign rd_sel[1] = cpu_rnw & sel2;
      assign pad1_d0   = sreg[1][0];
    end else begin : g_no_pad1
      assign pad1_d0 = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)            strobe <= 1'b0;
    else if (strobe_wr) strobe <= cpu_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '1;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (strobe_wr && strobe)
          sreg[p] <= load_src[p*NUM_BITS +: NUM_BITS];
        else if (strobe)
          sreg[p] <= pad_state[p*NUM_BITS +: NUM_BITS];
        else if (ph2_falling && rd_sel[p])
          sreg[p] <= {1'b1, sreg[p][NUM_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   cpu_data_out <= 8'd0;
    else if (ph2_falling)      cpu_data_out <= 8'd0;
    else if (rd_sel[0])        cpu_data_out <= {7'd0, sreg[0][0]};
    else if (cpu_rnw && sel2)  cpu_data_out <= {7'd0, pad1_d0};
    else                       cpu_data_out <= 8'd0;
  end

endmodule

// File: tb/tb_joypad_poller.sv
// Randomised self-checking bench for joypad_poller: serial pad models plus a
// snapshot / CPU-bit-queue reference model.
module tb_joypad_poller;
  import nes_io_pkg::*;

  localparam int NP = 2;
  localparam int NB = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ph2_falling = 1'b0;
  logic [15:0]    cpu_addr = 16'h0000;
  logic           cpu_rnw = 1'b1;
  logic           cpu_data_in = 1'b0;
  logic [7:0]     cpu_data_out;
  logic [NP-1:0]  pad_data_n;
  logic [NP-1:0]  pad_clk;
  logic           pad_latch;
  logic [NP*NB-1:0] pad_state;
  logic           scan_done;

  always #5 clk = ~clk;

  joypad_poller #(
    .NUM_PADS    (NP),
    .NUM_BITS    (NB),
    .HALF_CYC    (4),
    .LATCH_CYC   (12),
    .POLL_PERIOD (1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ph2_falling  (ph2_falling),
    .cpu_addr     (cpu_addr),
    .cpu_rnw      (cpu_rnw),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .pad_data_n   (pad_data_n),
    .pad_clk      (pad_clk),
    .pad_latch    (pad_latch),
    .pad_state    (pad_state),
    .scan_done    (scan_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [NB-1:0]    pad_val [NP];
  logic [NB-1:0]    pad_sh  [NP];
  logic [NP-1:0]    clk_prev;
  logic [NP*NB-1:0] lat_val;
  logic [NP*NB-1:0] model_snap;
  bit               model_strobe = 1'b0;
  bit               exp_q0[$];
  bit               exp_q1[$];

  // Pads behave like 4021s: load while latched, shift on pad_clk rising edges.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (pad_latch) pad_sh[p] = pad_val[p];
      else if (pad_clk[p] && !clk_prev[p]) pad_sh[p] = {1'b1, pad_sh[p][NB-1:1]};
    end
    clk_prev = pad_clk;
    if (rst) begin
      model_snap = '0;
    end else begin
      if (pad_latch) lat_val = {pad_val[1], pad_val[0]};
      if (scan_done) model_snap = lat_val;
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) pad_data_n[p] = ~pad_sh[p][0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP*NB-1:0] cur_snap();
    return scan_done ? lat_val : model_snap;
  endfunction

  task automatic load_q(input logic [NP*NB-1:0] s);
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < NB; i++) begin
      exp_q0.push_back(s[i]);
      exp_q1.push_back(s[NB+i]);
    end
  endtask

  // Called at a negedge; returns at a negedge one idle cycle after the write.
  task automatic cpu_write(input logic [15:0] a, input logic d);
    if (a == CONTROLLER1_ADDR) begin
      if (model_strobe && !d) load_q(cur_snap());
      model_strobe = d;
    end
    cpu_addr = a; cpu_rnw = 1'b0; cpu_data_in = d; ph2_falling = 1'b1;
    @(negedge clk);
    ph2_falling = 1'b0; cpu_rnw = 1'b1; cpu_addr = 16'h0000; cpu_data_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [15:0] a);
    logic e;
    if (model_strobe)
      e = (a == CONTROLLER1_ADDR) ? model_snap[0] : model_snap[NB];
    else if (a == CONTROLLER1_ADDR)
      e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 1'b1;
    else
      e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 1'b1;
    cpu_addr = a; cpu_rnw = 1'b1;
    @(negedge clk);
    chk((a == CONTROLLER1_ADDR) ? "rd_4016" : "rd_4017", cpu_data_out, {7'd0, e});
    ph2_falling = 1'b1;
    @(negedge clk);
    ph2_falling = 1'b0; cpu_addr = 16'h0000;
    chk("rd_clear", cpu_data_out, 0);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge clk);
      seen = scan_done;
    end
    chk("scan_wait", seen, 1);
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    model_strobe = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (3) @(negedge clk);
  endtask

  // Called at the negedge where rst is released; cycle n follows the n-th posedge.
  task automatic scan_timing();
    int  lat_n, lat_first, low_n, low_pulses, done_at, done_n, skew;
    logic prev;
    lat_n = 0; lat_first = 0; low_n = 0; low_pulses = 0;
    done_at = 0; done_n = 0; skew = 0; prev = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (pad_latch) begin
        lat_n++;
        if (lat_first == 0) lat_first = n;
      end
      if (!pad_clk[0]) begin
        low_n++;
        if (prev) low_pulses++;
      end
      if (pad_clk[1] != pad_clk[0]) skew++;
      prev = pad_clk[0];
      if (scan_done) begin
        done_n++;
        if (done_at == 0) done_at = n;
      end
    end
    chk("latch_first", lat_first, 1);
    chk("latch_len", lat_n, 12);
    chk("clk_pulses", low_pulses, NB);
    chk("clk_low_cyc", low_n, NB * 4);
    chk("clk_skew", skew, 0);
    chk("done_cycle", done_at, 77);
    chk("done_width", done_n, 1);
    chk("pad_state", pad_state, {pad_val[1], pad_val[0]});
  endtask

  initial begin
    pad_val[0] = 8'hA5;
    pad_val[1] = 8'h3C;

    hold_reset();
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 2'b11);
    chk("rst_dout", cpu_data_out, 0);
    chk("rst_state", pad_state, 0);
    chk("rst_done", scan_done, 0);
    rst = 1'b0;
    scan_timing();

    // Full CPU read of both pads, including the post-8 fill of ones.
    cpu_write(CONTROLLER1_ADDR, 1'b1);
    cpu_write(CONTROLLER1_ADDR, 1'b0);
    repeat (10) cpu_read(CONTROLLER1_ADDR);
    repeat (8) cpu_read(CONTROLLER2_ADDR);

    // Strobe held: every read returns snapshot bit 0.
    cpu_write(CONTROLLER1_ADDR, 1'b1);
    repeat (3) cpu_read(CONTROLLER1_ADDR);
    cpu_write(CONTROLLER1_ADDR, 1'b0);

    // Coherency: a new snapshot mid-read must not disturb the shift in progress.
    repeat (3) cpu_read(CONTROLLER1_ADDR);
    wait_done();
    pad_val[0] = 8'hFF;
    wait_done();
    repeat (7) cpu_read(CONTROLLER1_ADDR);
    chk("coh_state", pad_state, 16'h3CFF);
    cpu_write(CONTROLLER1_ADDR, 1'b1);
    cpu_write(CONTROLLER1_ADDR, 1'b0);
    repeat (9) cpu_read(CONTROLLER1_ADDR);

    // Bypass: strobe release on the COMMIT cycle loads the fresh snapshot.
    pad_val[0] = 8'h5A;
    cpu_write(CONTROLLER1_ADDR, 1'b1);
    wait_done();
    cpu_write(CONTROLLER1_ADDR, 1'b0);
    repeat (8) cpu_read(CONTROLLER1_ADDR);

    // Reset during LOW of bit 3 (scan cycle 42) of a later scan.
    wait_done();
    cpu_addr = CONTROLLER1_ADDR; cpu_rnw = 1'b1;
    repeat (965) @(negedge clk);
    chk("mid_low", pad_clk, 2'b00);
    chk("mid_dout", cpu_data_out, {7'd0, (exp_q0.size() > 0) ? exp_q0[0] : 1'b1});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_state", pad_state, 0);
    chk("mid_latch", pad_latch, 0);
    chk("mid_clk", pad_clk, 2'b11);
    chk("mid_dout0", cpu_data_out, 0);
    chk("mid_done", scan_done, 0);
    cpu_addr = 16'h0000;
    hold_reset();
    rst = 1'b0;
    scan_timing();

    // Random pad patterns and interleaved reads; $4017 writes must be ignored.
    for (int r = 0; r < 4; r++) begin
      pad_val[0] = 8'($urandom);
      pad_val[1] = 8'($urandom);
      wait_done();
      cpu_write(CONTROLLER1_ADDR, 1'b1);
      cpu_write(CONTROLLER1_ADDR, 1'b0);
      if ($urandom_range(1, 0) == 1) cpu_write(CONTROLLER2_ADDR, 1'b1);
      repeat ($urandom_range(12, 4))
        cpu_read(($urandom_range(1, 0) == 1) ? CONTROLLER2_ADDR : CONTROLLER1_ADDR);
      chk("rnd_state", pad_state, {pad_val[1], pad_val[0]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
